tmds_encoder: RTL and testbench
===============================

TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 Parameter CHANNEL, default 0, TMDS lane index (0..2); selects the video guard-band code.
REQ-002 clk  input  1  pixel clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 de  input  1  video data enable.
REQ-005 din  input  8  pixel component byte, valid when de=1.
REQ-006 c0, c1  input  1 each  control bits, used in control periods.
REQ-007 vgb  input  1  emit the video guard band this cycle.
REQ-008 island_en  input  1  emit the TERC4 data-island symbol this cycle.
REQ-009 aux  input  4  TERC4 nibble, valid when island_en=1.
REQ-010 dout  output  10  TMDS symbol, bit 0 serialized first, registered.

Function
REQ-011 Mode priority per cycle: de > vgb > island_en > control.
REQ-012 Fixed latency: 2 clk cycles from input sample to dout in every mode; mode changes never stall, drop or duplicate symbols.
REQ-013 Stage 1 registers: the mode, q_m[8:0], N1(q_m[7:0]) and N0(q_m[7:0]) (4-bit counts), and the control/guard/TERC4 code.
REQ-014 q_m rule: if N1(din)>4, or N1(din)=4 and din[0]=0, then XNOR chain with q_m[8]=0; otherwise XOR chain with q_m[8]=1; q_m[0]=din[0].
REQ-015 Stage 2 video, case A (cnt=0 or N1=N0): dout={~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}; cnt += q_m[8] ? (N1-N0) : (N0-N1).
REQ-016 Case B (cnt>0 and N1>N0, or cnt<0 and N0>N1): dout={1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (N0-N1).
REQ-017 Case C (otherwise): dout={0, q_m[8], q_m[7:0]}; cnt += (N1-N0) - 2*(~q_m[8]).
REQ-018 cnt is a 5-bit signed register, range -10..+10, arithmetic sign-extended.
REQ-019 Control codes {c1,c0}: 00=1101010100, 01=0010101011, 10=0101010100, 11=1010101011.
REQ-020 Guard band: CHANNEL 0 or 2 = 1011001100; CHANNEL 1 = 0100110011.
REQ-021 cnt is cleared to 0 on every non-video symbol (control, guard, TERC4).
REQ-022 A de 0->1 transition starts from cnt=0; back-to-back video symbols update cnt every cycle.

Reset
REQ-023 reset_n low: dout=1101010100 (control 00), cnt=0, stage-1 registers hold the control-00 state, all effective immediately without waiting for clk.
REQ-024 Reset release: the first two dout values after release are control 00; inputs sampled on the first rising edge appear 2 cycles later.
REQ-025 Reset asserted mid-stream discards both in-flight symbols.

Configuration
REQ-026 Macro TMDS_ENCODER_TERC4_EN defined: island_en selects the TERC4 table (HDMI 1.4 Table 5-15), e.g. aux 0000=1010011100, 0001=1001100011, 1111=1011000011.
REQ-027 Macro absent: island_en and aux ports remain but are ignored; those cycles encode as control per REQ-019; no TERC4 ROM is synthesized.

Verification
REQ-028 Reset, then de=1 with din=0x00 for 3 cycles -> dout=0x100, 0x3FF, 0x100; cnt=-8, +2, -6.
REQ-029 Control sweep: de=0 with {c1,c0}=00,01,10,11 -> the four REQ-019 codes, each 2 cycles later.
REQ-030 CHANNEL=1 with vgb=1 and de=0 -> dout=0100110011; with vgb and de both 1, the video symbol wins.
REQ-031 TERC4_EN defined, island_en=1, aux=0000 -> 1010011100; same stimulus without the macro, c1c0=00 -> 1101010100.
REQ-032 Random din for 10k cycles with random de gaps -> dout matches the reference model, every video symbol decodes back to din, and cnt stays within ±10.
REQ-033 Assert reset_n low during a video burst -> dout=1101010100 before the next clk edge and cnt=0; after release, the first video symbol matches case A.

Source files
------------

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b symbol encoder: two-stage pipeline for video, control, guard band and TERC4.
// Define TMDS_ENCODER_TERC4_EN to enable the TERC4 data-island table on island_en.
module tmds_encoder #(
  parameter int unsigned CHANNEL = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       de,
  input  logic [7:0] din,
  input  logic       c0,
  input  logic       c1,
  input  logic       vgb,
  input  logic       island_en,
  input  logic [3:0] aux,
  output logic [9:0] dout
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SYM_W  = 10;
  localparam int unsigned ONES_W = 4;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned SUM_W  = 6;

  localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;
  localparam logic [SYM_W-1:0] GUARD   = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;

  function automatic logic [ONES_W-1:0] ones8(input logic [DATA_W-1:0] v);
    logic [ONES_W-1:0] s;
    s = '0;
    for (int i = 0; i < int'(DATA_W); i++) s = s + ONES_W'(v[i]);
    return s;
  endfunction

`ifdef TMDS_ENCODER_TERC4_EN
  function automatic logic [SYM_W-1:0] terc4(input logic [3:0] a);
    logic [SYM_W-1:0] r;
    case (a)
      4'h0:    r = 10'b1010011100;
      4'h1:    r = 10'b1001100011;
      4'h2:    r = 10'b1011100100;
      4'h3:    r = 10'b1011100010;
      4'h4:    r = 10'b0101110001;
      4'h5:    r = 10'b0100011110;
      4'h6:    r = 10'b0110001110;
      4'h7:    r = 10'b0100111100;
      4'h8:    r = 10'b1011001100;
      4'h9:    r = 10'b0100111001;
      4'hA:    r = 10'b0110011100;
      4'hB:    r = 10'b1011000110;
      4'hC:    r = 10'b1010001110;
      4'hD:    r = 10'b1001110001;
      4'hE:    r = 10'b0101100011;
      default: r = 10'b1011000011;
    endcase
    return r;
  endfunction
`else
  logic unused_island;
  assign unused_island = ^{island_en, aux};
`endif

  // Stage 1 combinational: transition-minimised q_m and non-video code select
  logic [ONES_W-1:0] din_ones;
  logic              use_xnor;
  logic [DATA_W:0]   qm_c;
  logic [ONES_W-1:0] qm_ones_c;
  logic [SYM_W-1:0]  code_c;

  always_comb begin
    din_ones = ones8(din);
    use_xnor = (din_ones > 4'd4) || ((din_ones == 4'd4) && !din[0]);
    qm_c     = '0;
    qm_c[0]  = din[0];
    for (int i = 1; i < int'(DATA_W); i++) begin
      qm_c[i] = use_xnor ? ~(qm_c[i-1] ^ din[i]) : (qm_c[i-1] ^ din[i]);
    end
    qm_c[DATA_W] = ~use_xnor;
    qm_ones_c    = ones8(qm_c[DATA_W-1:0]);
  end

  always_comb begin
    case ({c1, c0})
      2'b00:   code_c = CTRL_00;
      2'b01:   code_c = CTRL_01;
      2'b10:   code_c = CTRL_10;
      default: code_c = CTRL_11;
    endcase
`ifdef TMDS_ENCODER_TERC4_EN
    if (island_en) code_c = terc4(aux);
`endif
    if (vgb) code_c = GUARD;
  end

  logic              s1_video;
  logic [DATA_W:0]   s1_qm;
  logic [ONES_W-1:0] s1_n1;
  logic [ONES_W-1:0] s1_n0;
  logic [SYM_W-1:0]  s1_code;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_video <= 1'b0;
      s1_qm    <= '0;
      s1_n1    <= '0;
      s1_n0    <= '0;
      s1_code  <= CTRL_00;
    end else begin
      s1_video <= de;
      s1_qm    <= qm_c;
      s1_n1    <= qm_ones_c;
      s1_n0    <= ONES_W'(DATA_W) - qm_ones_c;
      s1_code  <= code_c;
    end
  end

  // Stage 2 combinational: DC-balance decision and running disparity update
  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_nxt;
  logic signed [SUM_W-1:0] cnt_ext;
  logic signed [SUM_W-1:0] n1s;
  logic signed [SUM_W-1:0] n0s;
  logic signed [SUM_W-1:0] cnt_sum;
  logic [SYM_W-1:0]        dout_nxt;
  logic                    q8;
  logic                    cnt_pos;
  logic                    cnt_neg;

  always_comb begin
    dout_nxt = s1_code;
    cnt_nxt  = '0;
    cnt_sum  = '0;
    q8       = s1_qm[DATA_W];
    cnt_ext  = {cnt[CNT_W-1], cnt};
    n1s      = signed'({2'b00, s1_n1});
    n0s      = signed'({2'b00, s1_n0});
    cnt_neg  = cnt[CNT_W-1];
    cnt_pos  = !cnt[CNT_W-1] && (cnt != '0);
    if (s1_video) begin
      if ((cnt == '0) || (s1_n1 == s1_n0)) begin
        dout_nxt = {~q8, q8, q8 ? s1_qm[DATA_W-1:0] : ~s1_qm[DATA_W-1:0]};
        cnt_sum  = q8 ? (cnt_ext + (n1s - n0s)) : (cnt_ext + (n0s - n1s));
      end else if ((cnt_pos && (s1_n1 > s1_n0)) || (cnt_neg && (s1_n0 > s1_n1))) begin
        dout_nxt = {1'b1, q8, ~s1_qm[DATA_W-1:0]};
        cnt_sum  = cnt_ext + (q8 ? 6'sd2 : 6'sd0) + (n0s - n1s);
      end else begin
        dout_nxt = {1'b0, q8, s1_qm[DATA_W-1:0]};
        cnt_sum  = cnt_ext + (n1s - n0s) - (q8 ? 6'sd0 : 6'sd2);
      end
      cnt_nxt = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout <= CTRL_00;
      cnt  <= '0;
    end else begin
      dout <= dout_nxt;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: lane 0 and lane 1 instances against a symbol-level model.
// Honors TMDS_ENCODER_TERC4_EN the same way the design does.
module tb_tmds_encoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       de = 1'b0;
  logic [7:0] din = '0;
  logic       c0 = 1'b0;
  logic       c1 = 1'b0;
  logic       vgb = 1'b0;
  logic       island_en = 1'b0;
  logic [3:0] aux = '0;
  logic [9:0] dout0;
  logic [9:0] dout1;

  always #5 clk = ~clk;

  tmds_encoder #(.CHANNEL(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .de(de), .din(din), .c0(c0), .c1(c1),
    .vgb(vgb), .island_en(island_en), .aux(aux), .dout(dout0)
  );

  tmds_encoder #(.CHANNEL(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .de(de), .din(din), .c0(c0), .c1(c1),
    .vgb(vgb), .island_en(island_en), .aux(aux), .dout(dout1)
  );

  typedef struct {
    logic [9:0] e0;
    logic [9:0] e1;
    int         cnt;
    bit         video;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];
  int   m_cnt;
  int   checks = 0;
  int   errors = 0;
  logic [9:0] last_dout;
  int   last_cnt;

  logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] terc_tab [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  // Reference video encoding from the minimisation and DC-balance rules
  function automatic logic [9:0] enc_video(input logic [7:0] d, input int cin, output int cout);
    int         n1d, n1, n0;
    bit         xn;
    logic [7:0] qm;
    logic       q8;
    logic [9:0] o;
    n1d = $countones(d);
    xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8 = ~xn;
    n1 = $countones(qm);
    n0 = 8 - n1;
    if (cin == 0 || n1 == n0) begin
      if (q8) begin o = {2'b01, qm};  cout = cin + n1 - n0; end
      else    begin o = {2'b10, ~qm}; cout = cin + n0 - n1; end
    end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
      o = {1'b1, q8, ~qm};
      cout = cin + (q8 ? 2 : 0) + n0 - n1;
    end else begin
      o = {1'b0, q8, qm};
      cout = cin + n1 - n0 - (q8 ? 0 : 2);
    end
    return o;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] v, r;
    v = s[9] ? ~s[7:0] : s[7:0];
    r[0] = v[0];
    for (int i = 1; i < 8; i++) r[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    return r;
  endfunction

  task automatic model_reset();
    exp_t e;
    q.delete();
    m_cnt = 0;
    e.e0 = ctrl_tab[0]; e.e1 = ctrl_tab[0]; e.cnt = 0; e.video = 1'b0; e.d = '0;
    q.push_back(e);
  endtask

  // One clock: drive inputs, let the edge sample them, compare the symbol now on dout
  task automatic step(input logic i_de, input logic [7:0] i_din, input logic [1:0] i_c,
                      input logic i_vgb, input logic i_isl, input logic [3:0] i_aux);
    exp_t e, got;
    int   nc, act;
    logic [9:0] nv;
    de = i_de; din = i_din; c1 = i_c[1]; c0 = i_c[0];
    vgb = i_vgb; island_en = i_isl; aux = i_aux;
    @(posedge clk);
    #1;
    e.d = i_din; e.video = i_de;
    if (i_de) begin
      e.e0 = enc_video(i_din, m_cnt, nc);
      e.e1 = e.e0;
      m_cnt = nc;
    end else begin
      nv = ctrl_tab[i_c];
`ifdef TMDS_ENCODER_TERC4_EN
      if (i_isl) nv = terc_tab[i_aux];
`endif
      e.e0 = i_vgb ? 10'b1011001100 : nv;
      e.e1 = i_vgb ? 10'b0100110011 : nv;
      m_cnt = 0;
    end
    e.cnt = m_cnt;
    q.push_back(e);
    got = q.pop_front();
    act = dut0.cnt;
    last_dout = dout0;
    last_cnt  = act;
    checks++;
    if (dout0 !== got.e0) begin
      errors++;
      $display("FAIL dout_ch0 t=%0t got=%b exp=%b", $time, dout0, got.e0);
    end
    checks++;
    if (dout1 !== got.e1) begin
      errors++;
      $display("FAIL dout_ch1 t=%0t got=%b exp=%b", $time, dout1, got.e1);
    end
    checks++;
    if (act != got.cnt) begin
      errors++;
      $display("FAIL cnt t=%0t got=%0d exp=%0d", $time, act, got.cnt);
    end
    if (got.video) begin
      checks++;
      if (decode(dout0) !== got.d) begin
        errors++;
        $display("FAIL decode t=%0t got=%h exp=%h", $time, decode(dout0), got.d);
      end
      checks++;
      if (act > 10 || act < -10) begin
        errors++;
        $display("FAIL cnt_range t=%0t got=%0d exp=-10..10", $time, act);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic check_reset_state(input string tag);
    int act;
    act = dut0.cnt;
    checks++;
    if (dout0 !== 10'b1101010100 || dout1 !== 10'b1101010100) begin
      errors++;
      $display("FAIL %s_dout got=%b/%b exp=1101010100", tag, dout0, dout1);
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL %s_cnt got=%0d exp=0", tag, act);
    end
  endtask

  task automatic test_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("reset_async");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    check_reset_state("reset_release");
    idle(3);
  endtask

  task automatic test_video_zero();
    int         exp_cnt [3] = '{-8, 2, -6};
    logic [9:0] exp_sym [3] = '{10'h100, 10'h3FF, 10'h100};
    step(1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) step(1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 4'h0);
      else       idle(1);
      checks++;
      if (last_dout !== exp_sym[i] || last_cnt != exp_cnt[i]) begin
        errors++;
        $display("FAIL video_zero_%0d got=%h/%0d exp=%h/%0d", i, last_dout, last_cnt, exp_sym[i], exp_cnt[i]);
      end
    end
    idle(1);
  endtask

  task automatic test_control();
    for (int i = 0; i < 4; i++) step(1'b0, 8'hA5, 2'(i), 1'b0, 1'b0, 4'h0);
    idle(2);
  endtask

  task automatic test_guard();
    step(1'b0, 8'h00, 2'b11, 1'b1, 1'b0, 4'h0);
    step(1'b1, 8'h3C, 2'b00, 1'b1, 1'b0, 4'h0);
    step(1'b0, 8'h00, 2'b01, 1'b1, 1'b1, 4'h5);
    idle(2);
  endtask

  task automatic test_island();
    step(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 4'h0);
    step(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 4'h1);
    step(1'b0, 8'h00, 2'b10, 1'b0, 1'b1, 4'hF);
    step(1'b1, 8'hFF, 2'b00, 1'b0, 1'b1, 4'h3);
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      logic r_de;
      r_de = ($urandom_range(0, 9) < 8);
      step(r_de, 8'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), 4'($urandom));
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 2'b00, 1'b0, 1'b0, 4'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("reset_mid");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    step(1'b1, 8'h5A, 2'b00, 1'b0, 1'b0, 4'h0);
    step(1'b1, 8'h0F, 2'b00, 1'b0, 1'b0, 4'h0);
    checks++;
    if (last_dout[9] === last_dout[8]) begin
      errors++;
      $display("FAIL reset_mid_caseA got=%b exp=bit9!=bit8", last_dout);
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_video_zero();
    test_control();
    test_guard();
    test_island();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
